// File: rtl/axilab_slave_alarm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axilab_slave_alarm                                           |
// | Description : AXI4-Lite slave holding the alarm registers. Synchronises    |
// |               raw sensor inputs, latches armed rising edges into sticky    |
// |               STATUS flags, counts events, raises a level interrupt and    |
// |               drives the LED bank.                                         |
// | Ports       : S_AXI_*    AXI4-Lite slave (one outstanding read and one     |
// |                          outstanding write, independent channels)         |
// |               sensor_in  asynchronous raw sensor levels                    |
// |               leds       LED drive (override pattern or alarm blink)       |
// |               irq        high while any STATUS bit is set                  |
// | Registers   : 0x0 CTRL   [0] ARM, [1] LED_OVR                              |
// |               0x4 LED    [7:0] pattern                                     |
// |               0x8 STATUS sticky event flags, write 1 to clear              |
// |               0xC EVCNT  saturating event count, any write clears          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axilab_slave_alarm #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int N_SENSORS          = 8
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESET,
   // write address channel
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   // write data channel
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   // write response channel
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   // read address channel
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   // read data channel
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   // alarm side
   input  logic [N_SENSORS-1:0]              sensor_in,
   output logic [7:0]                        leds,
   output logic                              irq
);

   // Blink toggle flips once per full wrap of this counter.
   localparam int BLINK_BITS = 24;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_LED    = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_EVCNT  = 2'd3;

   typedef enum logic [1:0] {
      WR_IDLE   = 2'd0,
      WR_ACCEPT = 2'd1,
      WR_RESP   = 2'd2
   } wr_state_t;

   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_ACCEPT = 2'd1,
      RD_DATA   = 2'd2
   } rd_state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   wr_state_t                     wr_state_q;
   logic                          awready_q;
   logic                          bvalid_q;

   rd_state_t                     rd_state_q;
   logic                          arready_q;
   logic                          rvalid_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

   logic [1:0]                    ctrl_q,   ctrl_d;
   logic [7:0]                    led_q,    led_d;
   logic [N_SENSORS-1:0]          status_q, status_d;
   logic [31:0]                   evcnt_q,  evcnt_d;
   logic                          irq_q;

   logic [N_SENSORS-1:0]          sync1_q;
   logic [N_SENSORS-1:0]          sync2_q;
   logic [N_SENSORS-1:0]          prev_q;

   logic [BLINK_BITS-1:0]         blink_cnt_q;
   logic                          toggle_q;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic                          w_wr_en;
   logic [1:0]                    w_wr_sel;
   logic                          w_any_strb;
   logic [N_SENSORS-1:0]          w_edges;
   logic [3:0]                    w_edge_cnt;
   logic [N_SENSORS-1:0]          w_clr;
   logic [32:0]                   w_sum;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_mux;

   function automatic logic [3:0] f_popcount(input logic [N_SENSORS-1:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < N_SENSORS; i++) begin
         n = n + {3'd0, v[i]};
      end
      return n;
   endfunction

   // The write lands during the single cycle both readies are high; the
   // master is still holding address, data and strobes at that point.
   assign w_wr_en    = (wr_state_q == WR_ACCEPT);
   assign w_wr_sel   = S_AXI_AWADDR[3:2];
   assign w_any_strb = |S_AXI_WSTRB;

   // Only edges seen while armed are events.
   assign w_edges    = sync2_q & ~prev_q & {N_SENSORS{ctrl_q[0]}};
   assign w_edge_cnt = f_popcount(w_edges);

   assign w_clr = (w_wr_en && (w_wr_sel == REG_STATUS) && w_any_strb)
                  ? S_AXI_WDATA[N_SENSORS-1:0] : '0;

   assign w_sum = {1'b0, evcnt_q} + {29'd0, w_edge_cnt};

   always_comb begin
      ctrl_d = ctrl_q;
      led_d  = led_q;

      if (w_wr_en && S_AXI_WSTRB[0]) begin
         if (w_wr_sel == REG_CTRL) begin
            ctrl_d = S_AXI_WDATA[1:0];
         end
         if (w_wr_sel == REG_LED) begin
            led_d = S_AXI_WDATA[7:0];
         end
      end

      // Clear is applied first so a same-cycle edge wins.
      status_d = (status_q & ~w_clr) | w_edges;

      // A counter write restarts from this cycle's edges rather than losing them.
      if (w_wr_en && (w_wr_sel == REG_EVCNT) && w_any_strb) begin
         evcnt_d = {28'd0, w_edge_cnt};
      end else if (w_sum[32]) begin
         evcnt_d = 32'hFFFF_FFFF;
      end else begin
         evcnt_d = w_sum[31:0];
      end
   end

   always_comb begin
      w_rd_mux = '0;
      case (S_AXI_ARADDR[3:2])
         REG_CTRL:   w_rd_mux[1:0]           = ctrl_q;
         REG_LED:    w_rd_mux[7:0]           = led_q;
         REG_STATUS: w_rd_mux[N_SENSORS-1:0] = status_q;
         default:    w_rd_mux                = evcnt_q;
      endcase
   end

   // ------------------------------------------------------------------------
   // Write channel: accept only when address and data are both present
   // ------------------------------------------------------------------------
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         wr_state_q <= WR_IDLE;
         awready_q  <= 1'b0;
         bvalid_q   <= 1'b0;
      end else begin
         case (wr_state_q)
            WR_IDLE: begin
               if (S_AXI_AWVALID && S_AXI_WVALID) begin
                  awready_q  <= 1'b1;
                  wr_state_q <= WR_ACCEPT;
               end
            end
            WR_ACCEPT: begin
               awready_q  <= 1'b0;
               bvalid_q   <= 1'b1;
               wr_state_q <= WR_RESP;
            end
            WR_RESP: begin
               if (S_AXI_BREADY) begin
                  bvalid_q   <= 1'b0;
                  wr_state_q <= WR_IDLE;
               end
            end
            default: begin
               awready_q  <= 1'b0;
               bvalid_q   <= 1'b0;
               wr_state_q <= WR_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Read channel: data is captured while ARREADY is high
   // ------------------------------------------------------------------------
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         rd_state_q <= RD_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
      end else begin
         case (rd_state_q)
            RD_IDLE: begin
               if (S_AXI_ARVALID) begin
                  arready_q  <= 1'b1;
                  rd_state_q <= RD_ACCEPT;
               end
            end
            RD_ACCEPT: begin
               arready_q  <= 1'b0;
               rdata_q    <= w_rd_mux;
               rvalid_q   <= 1'b1;
               rd_state_q <= RD_DATA;
            end
            RD_DATA: begin
               if (S_AXI_RREADY) begin
                  rvalid_q   <= 1'b0;
                  rd_state_q <= RD_IDLE;
               end
            end
            default: begin
               arready_q  <= 1'b0;
               rvalid_q   <= 1'b0;
               rd_state_q <= RD_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Registers, sensor path and blink generator
   // ------------------------------------------------------------------------
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         ctrl_q      <= '0;
         led_q       <= '0;
         status_q    <= '0;
         evcnt_q     <= '0;
         irq_q       <= 1'b0;
         sync1_q     <= '0;
         sync2_q     <= '0;
         prev_q      <= '0;
         blink_cnt_q <= '0;
         toggle_q    <= 1'b0;
      end else begin
         ctrl_q      <= ctrl_d;
         led_q       <= led_d;
         status_q    <= status_d;
         evcnt_q     <= evcnt_d;
         // Registered from next-state so irq tracks STATUS with no extra lag.
         irq_q       <= |status_d;
         sync1_q     <= sensor_in;
         sync2_q     <= sync1_q;
         prev_q      <= sync2_q;
         blink_cnt_q <= blink_cnt_q + 1'b1;
         if (&blink_cnt_q) begin
            toggle_q <= ~toggle_q;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = awready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;
   assign irq           = irq_q;

   assign leds = ctrl_q[1]               ? led_q :
                 (ctrl_q[0] && irq_q)    ? {8{toggle_q}} :
                                           8'h00;

   // Inputs the register map does not decode.
   logic w_unused_ok;
   assign w_unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                          S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                          S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:8]};

endmodule
`default_nettype wire

// File: tb/tb_axilab_slave_alarm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axilab_slave_alarm                                        |
// | Description : Scoreboard bench for axilab_slave_alarm. Drivers push the    |
// |               expected response when a transaction is issued; a monitor    |
// |               pops and compares on every B/R handshake.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_axilab_slave_alarm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b1;
   logic [3:0]  araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b1;
   logic [7:0]  sensor = '0;
   logic [7:0]  leds;
   logic        irq;

   always #5 clk = ~clk;

   axilab_slave_alarm #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(4),
      .N_SENSORS(8)
   ) dut (
      .S_AXI_ACLK(clk),       .S_AXI_ARESET(rst),
      .S_AXI_AWADDR(awaddr),  .S_AXI_AWPROT(awprot),
      .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata),    .S_AXI_WSTRB(wstrb),
      .S_AXI_WVALID(wvalid),  .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp),    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr),  .S_AXI_ARPROT(arprot),
      .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata),    .S_AXI_RRESP(rresp),
      .S_AXI_RVALID(rvalid),  .S_AXI_RREADY(rready),
      .sensor_in(sensor),     .leds(leds), .irq(irq)
   );

   int checks = 0;
   int errors = 0;
   int bcount = 0;

   logic [31:0] rq[$];
   logic [1:0]  bq[$];

   // Reference model of the programmer-visible registers.
   logic [1:0]  m_ctrl   = '0;
   logic [7:0]  m_led    = '0;
   logic [7:0]  m_status = '0;
   logic [31:0] m_evcnt  = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s timed out", name);
   endtask

   function automatic logic [31:0] popc(input logic [7:0] v);
      logic [31:0] n = 0;
      for (int i = 0; i < 8; i++) if (v[i]) n++;
      return n;
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   function automatic logic [31:0] model_read(input logic [3:0] a);
      case (a[3:2])
         2'd0:    return {30'd0, m_ctrl};
         2'd1:    return {24'd0, m_led};
         2'd2:    return {24'd0, m_status};
         default: return m_evcnt;
      endcase
   endfunction

   task automatic apply_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      case (a[3:2])
         2'd0:    if (s[0]) m_ctrl = d[1:0];
         2'd1:    if (s[0]) m_led = d[7:0];
         2'd2:    if (s != 4'd0) m_status = m_status & ~d[7:0];
         default: if (s != 4'd0) m_evcnt = 32'd0;
      endcase
   endtask

   // Monitor: samples just after the falling edge so driver updates are settled.
   always begin
      @(negedge clk);
      #1;
      if (!rst) begin
         if (rvalid && rready) begin
            if (rq.size() == 0) begin
               timeout("unexpected_rvalid");
            end else begin
               chk("rdata", rdata, rq.pop_front());
               chk("rresp", 32'(rresp), 32'd0);
            end
         end
         if (bvalid && bready) begin
            bcount++;
            if (bq.size() == 0) begin
               timeout("unexpected_bvalid");
            end else begin
               chk("bresp", 32'(bresp), 32'(bq.pop_front()));
            end
         end
         if (awready || wready) chk("aw_w_ready_pair", 32'(awready), 32'(wready));
      end
   end

   // All driver tasks are entered at a falling edge.
   task automatic wr_start(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1;
      apply_write(a, d, s);
      bq.push_back(2'b00);
      n = 0;
      do begin @(negedge clk); n++; end while (!awready && n < 40);
      if (!awready) timeout("awready");
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic wr_finish();
      int n = 0;
      while (bvalid && n < 40) begin @(negedge clk); n++; end
      if (bvalid) timeout("bvalid_release");
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      wr_start(a, d, s);
      wr_finish();
   endtask

   task automatic rd(input logic [3:0] a);
      int n;
      araddr = a; arvalid = 1'b1;
      rq.push_back(model_read(a));
      n = 0;
      do begin @(negedge clk); n++; end while (!arready && n < 40);
      if (!arready) timeout("arready");
      @(negedge clk);
      arvalid = 1'b0;
      n = 0;
      while (rvalid && n < 40) begin @(negedge clk); n++; end
      if (rvalid) timeout("rvalid_release");
   endtask

   task automatic pulse(input logic [7:0] mask);
      sensor = mask;
      repeat (4) @(negedge clk);
      sensor = 8'h00;
      repeat (4) @(negedge clk);
      if (m_ctrl[0]) begin
         m_status = m_status | mask;
         m_evcnt  = sat_add(m_evcnt, popc(mask));
      end
   endtask

   task automatic check_outputs();
      chk("irq", 32'(irq), 32'(m_status != 8'd0));
      chk("leds", 32'(leds), m_ctrl[1] ? 32'(m_led) : 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0;
      int n;
      repeat (3) @(negedge clk);
      #2;
      chk("reset_awready", 32'(awready), 32'd0);
      chk("reset_wready", 32'(wready), 32'd0);
      chk("reset_arready", 32'(arready), 32'd0);
      chk("reset_bvalid", 32'(bvalid), 32'd0);
      chk("reset_rvalid", 32'(rvalid), 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_leds", 32'(leds), 32'd0);
      chk("reset_irq", 32'(irq), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Basic register access and LED override.
      wr(4'h0, 32'h0000_0003, 4'hF);
      wr(4'h4, 32'h0000_00A5, 4'hF);
      rd(4'h0);
      rd(4'h4);
      check_outputs();

      // Address arrives three cycles before data.
      b0 = bcount;
      awaddr = 4'h4; wdata = 32'h0000_005A; wstrb = 4'hF; awvalid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("early_aw_awready", 32'(awready), 32'd0);
         chk("early_aw_wready", 32'(wready), 32'd0);
      end
      wvalid = 1'b1;
      apply_write(4'h4, 32'h0000_005A, 4'hF);
      bq.push_back(2'b00);
      @(negedge clk);
      chk("late_w_awready", 32'(awready), 32'd1);
      chk("late_w_wready", 32'(wready), 32'd1);
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      chk("late_w_ready_drop", 32'(awready), 32'd0);
      wr_finish();
      repeat (2) @(negedge clk);
      chk("bvalid_count", 32'(bcount - b0), 32'd1);
      rd(4'h4);

      // Armed edges, three-edge latency, W1C and interrupt.
      wr(4'h0, 32'h1, 4'hF);
      wr(4'hC, 32'h0, 4'hF);
      wr(4'h8, 32'hFF, 4'hF);
      sensor = 8'h04;
      @(negedge clk);
      @(negedge clk);
      chk("irq_after_2_edges", 32'(irq), 32'd0);
      @(negedge clk);
      chk("irq_after_3_edges", 32'(irq), 32'd1);
      m_status = m_status | 8'h04;
      m_evcnt  = sat_add(m_evcnt, 32'd1);
      sensor = 8'h00;
      repeat (4) @(negedge clk);
      pulse(8'h20);
      rd(4'h8);
      rd(4'hC);
      check_outputs();
      wr(4'h8, 32'h04, 4'hF);
      rd(4'h8);
      check_outputs();
      wr(4'h8, 32'h20, 4'hF);
      check_outputs();

      // Disarmed: edges are ignored.
      wr(4'h0, 32'h0, 4'hF);
      pulse(8'h01);
      rd(4'h8);
      rd(4'hC);
      check_outputs();

      // Back-pressure on B blocks the next write.
      wr(4'h0, 32'h1, 4'hF);
      bready = 1'b0;
      wr_start(4'h4, 32'h11, 4'hF);
      awaddr = 4'h4; wdata = 32'h3C; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("bp_bvalid_held", 32'(bvalid), 32'd1);
         chk("bp_no_accept", 32'(awready), 32'd0);
      end
      bready = 1'b1;
      wr_start(4'h4, 32'h3C, 4'hF);
      wr_finish();
      rd(4'h4);

      // Byte strobes and zero-strobe writes.
      wr(4'h4, 32'h0, 4'hF);
      wr(4'h4, 32'hFFFF_FFFF, 4'h1);
      rd(4'h4);
      wr(4'h4, 32'hFFFF_FF00, 4'hE);
      rd(4'h4);
      pulse(8'h42);
      wr(4'h8, 32'hFF, 4'h0);
      wr(4'hC, 32'h0, 4'h0);
      rd(4'h8);
      rd(4'hC);

      // Edge coincident with W1C of the same bit: set wins.
      pulse(8'h08);
      sensor = 8'h08;
      @(negedge clk);
      wr_start(4'h8, 32'h08, 4'h1);
      wr_finish();
      m_status = m_status | 8'h08;
      m_evcnt  = sat_add(m_evcnt, 32'd1);
      sensor = 8'h00;
      repeat (4) @(negedge clk);
      rd(4'h8);

      // Edge coincident with counter clear: counter holds that cycle's edges.
      sensor = 8'h90;
      @(negedge clk);
      wr_start(4'hC, 32'h0, 4'hF);
      wr_finish();
      m_status = m_status | 8'h90;
      m_evcnt  = 32'd2;
      sensor = 8'h00;
      repeat (4) @(negedge clk);
      rd(4'hC);
      rd(4'h8);

      // Randomised traffic against the model.
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0, 1: wr(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
            2:    rd(4'($urandom_range(0, 15)));
            default: pulse(8'($urandom));
         endcase
         check_outputs();
      end

      // Reset while a read response is pending.
      wr(4'h0, 32'h3, 4'hF);
      wr(4'h4, 32'h77, 4'hF);
      pulse(8'h81);
      rready = 1'b0;
      araddr = 4'h4; arvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!arready && n < 40);
      if (!arready) timeout("rst_arready");
      @(negedge clk);
      arvalid = 1'b0;
      chk("rst_rvalid_pending", 32'(rvalid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_rvalid", 32'(rvalid), 32'd0);
      chk("rst_async_arready", 32'(arready), 32'd0);
      chk("rst_async_bvalid", 32'(bvalid), 32'd0);
      chk("rst_async_irq", 32'(irq), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      rready = 1'b1;
      m_ctrl = '0; m_led = '0; m_status = '0; m_evcnt = '0;
      @(negedge clk);
      check_outputs();
      rd(4'h0);
      rd(4'h4);
      rd(4'h8);
      rd(4'hC);

      repeat (4) @(negedge clk);
      chk("rq_drained", 32'(rq.size()), 32'd0);
      chk("bq_drained", 32'(bq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
